instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Instruction issuer for the grupo 4 simple processor: the memory-side counterpart of the control unit. It reads 9-bit instruction words (IIIXXXYYY) from a synchronous program memory, presents each on the processor's DIN bus with a one-cycle Run pulse, and supplies the immediate word for mvi. It then waits for the processor's Done before advancing its program counter. It sits between the program ROM and the processor datapath and replaces manual Run/DIN switches on the board.

## Interface
- ADDR_W, 5: program memory address width; program counter wraps modulo 2^ADDR_W.
- TIMEOUT, 15: maximum cycles spent waiting for Done before flagging Error (1..255).
- Clock  in  1  single system clock; all state changes on rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Start  in  1  begin execution from address 0; sampled only in IDLE, HALT, ERROR.
- MemData  in  9  program memory read data; valid one cycle after the address is presented.
- Done  in  1  processor instruction-complete pulse.
- MemAddr  out  ADDR_W  program memory read address.
- DIN  out  9  word driven onto the processor DIN bus.
- Run  out  1  one-cycle instruction start pulse.
- Busy  out  1  high in every state except IDLE, HALT, ERROR.
- Halted  out  1  halt opcode reached.
- Error  out  1  Done timeout occurred (sticky).
- InstrCount  out  8  retired instructions, saturating at 255.

## Operation
- Opcodes: 000 mv, 001 mvi (two words), 010 add, 011 sub, 111 halt. 100–110 are issued like add (single word, wait for Done).
- States: IDLE, FETCH, LATCH, ISSUE, IMM, WAIT, HALT, ERROR.
- IDLE: all outputs at reset value. On Start=1: PC<=0, InstrCount<=0, go to FETCH.
- FETCH: MemAddr=PC. Next state is LATCH.
- LATCH: IRbuf<=MemData.
  - If MemData[8:6]==111: go to HALT. The halt word is not counted and Run is not asserted.
  - Otherwise go to ISSUE.
- ISSUE: DIN=IRbuf, Run=1, wait counter cleared. Done is ignored in this cycle.
  - mvi: MemAddr=PC+1 (wrapped), next state IMM.
  - Other opcodes: next state WAIT.
- IMM: DIN=MemData (the immediate), and the value is captured into IMMbuf.
  - Done=1 in this cycle retires the instruction at once (same rule as WAIT).
  - Otherwise go to WAIT.
- WAIT: DIN holds IRbuf (non-mvi) or IMMbuf (mvi).
  - On Done=1: PC<=PC+1 (or PC+2 for mvi, both modulo 2^ADDR_W), InstrCount<=sat(InstrCount+1), go to FETCH.
  - Each cycle without Done increments the wait counter. When the counter reaches TIMEOUT, go to ERROR.
- HALT: Halted=1, Busy=0, DIN=0. Start=1 restarts exactly as from IDLE, clearing Halted.
- ERROR: Error=1, Busy=0, Run=0, DIN=0. Start=1 restarts as from IDLE, clearing Error. Only Start or Resetn leave ERROR.
- Start is ignored while Busy. Done is ignored outside IMM/WAIT.
- MemAddr:
  - PC in IDLE, FETCH, LATCH, WAIT, HALT, ERROR.
  - PC+1 (wrapped) in ISSUE and IMM for mvi.
- DIN is 0 in IDLE, FETCH, LATCH, HALT, ERROR.

## Timing
- Reset (asynchronous, immediate on Resetn=0): state IDLE, PC=0, MemAddr=0, DIN=0, Run=0, Busy=0, Halted=0, Error=0, InstrCount=0, wait counter=0.
- Reset mid-operation aborts the instruction; Run never glitches high.
- Start sampled at edge E0 gives FETCH in cycle 1, LATCH in cycle 2, ISSUE (Run=1) in cycle 3.
- The processor captures IR on the edge ending the Run cycle.
- For mvi, the immediate is on DIN in the cycle after Run (processor T1) and is held until Done.
- Minimum issue-to-issue spacing with Done in the first eligible cycle is 4 cycles: ISSUE, IMM/WAIT, FETCH, LATCH.
- Wrap: after mvi at address 2^ADDR_W−1, the immediate is read from address 0 and the next fetch is from address 1.
- Timeout: if Done never arrives, Error asserts in the cycle after exactly TIMEOUT cycles in WAIT.

## Test plan
- mv then halt: mem[0]=0x00A, mem[1]=0x1C0.
  - Start, then Run=1 with DIN=0x00A in cycle 3.
  - Done in cycle 4, then MemAddr=1 in cycle 5, then Halted=1 in cycle 7.
  - InstrCount=1, Busy=0.
- mvi: mem[0]=0x058, mem[1]=0x0AB, mem[2]=0x1C0.
  - Run with DIN=0x058, then DIN=0x0AB the next cycle.
  - Done in the IMM cycle gives the next fetch at MemAddr=2, then Halted=1 with InstrCount=1.
- Timeout: mem[0]=0x091 (add) with Done held 0.
  - Error=1 after 15 WAIT cycles; Busy=0, Run stays 0.
  - Start then restarts at MemAddr=0 with Error cleared.
- Wrap with ADDR_W=2: PC=3 holds mvi 0x040, mem[0]=0x055, mem[1]=halt.
  - Immediate read from MemAddr=0, next fetch from MemAddr=1, then Halted=1.
- Reset mid-WAIT: pulse Resetn=0 while Busy.
  - All outputs 0 immediately.
  - Start then fetches from address 0 and InstrCount restarts at 0.
- Ignored inputs: Start pulsed in WAIT, and Done pulsed in ISSUE.
  - No restart and no retirement; PC advances only on a Done seen in IMM/WAIT.
  - With 256 mv instructions retired, InstrCount saturates at 255.

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction issuer for the grupo 4 processor: fetches IIIXXXYYY words from a
// synchronous ROM, pulses Run with the word on DIN, supplies mvi immediates and waits for Done.
module instr_sequencer #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic [8:0]        MemData,
  input  logic              Done,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [8:0]        DIN,
  output logic              Run,
  output logic              Busy,
  output logic              Halted,
  output logic              Error,
  output logic [7:0]        InstrCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_IMM,
    S_WAIT,
    S_HALT,
    S_ERROR
  } state_t;

  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [8:0]        ir_q, ir_d;
  logic [8:0]        imm_q, imm_d;
  logic [7:0]        wait_q, wait_d;
  logic [7:0]        count_q, count_d;

  logic              is_mvi;
  logic              retire;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] pc_plus2;
  logic [7:0]        wait_inc;

  assign is_mvi   = (ir_q[8:6] == OP_MVI);
  assign pc_plus1 = pc_q + ADDR_W'(1);
  assign pc_plus2 = pc_q + ADDR_W'(2);
  assign wait_inc = wait_q + 8'd1;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      imm_q   <= '0;
      wait_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    wait_d  = wait_q;
    count_d = count_q;
    retire  = 1'b0;

    case (state_q)
      S_IDLE, S_HALT, S_ERROR: begin
        if (Start) begin
          pc_d    = '0;
          count_d = '0;
          wait_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        ir_d    = MemData;
        state_d = (MemData[8:6] == OP_HALT) ? S_HALT : S_ISSUE;
      end
      S_ISSUE: begin
        wait_d  = '0;
        state_d = is_mvi ? S_IMM : S_WAIT;
      end
      S_IMM: begin
        imm_d = MemData;
        if (Done) retire = 1'b1;
        else      state_d = S_WAIT;
      end
      S_WAIT: begin
        if (Done) begin
          retire = 1'b1;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == TIMEOUT_C) state_d = S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // mvi consumed two ROM words, so it advances the PC past its immediate.
    if (retire) begin
      pc_d    = is_mvi ? pc_plus2 : pc_plus1;
      count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
      state_d = S_FETCH;
    end
  end

  always_comb begin
    MemAddr = pc_q;
    DIN     = '0;
    Run     = 1'b0;
    Busy    = 1'b1;
    Halted  = 1'b0;
    Error   = 1'b0;

    case (state_q)
      S_IDLE:  Busy = 1'b0;
      S_HALT: begin
        Busy   = 1'b0;
        Halted = 1'b1;
      end
      S_ERROR: begin
        Busy  = 1'b0;
        Error = 1'b1;
      end
      S_ISSUE: begin
        DIN = ir_q;
        Run = 1'b1;
        if (is_mvi) MemAddr = pc_plus1;
      end
      S_IMM: begin
        DIN     = MemData;
        MemAddr = pc_plus1;
      end
      S_WAIT:  DIN = is_mvi ? imm_q : ir_q;
      default: ;
    endcase
  end

  assign InstrCount = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: vector table, directed corner sequences and random
// straight-line programs checked against a program-walking reference model.
module tb_instr_sequencer;
  localparam int unsigned AW = 5;
  localparam int unsigned TO = 15;
  localparam logic [8:0] HALTW = 9'h1C0;

  logic          Clock = 1'b0;
  logic          Resetn, Start, Done, Start2, Done2;
  logic [8:0]    MemData, MemData2, DIN, DIN2;
  logic [AW-1:0] MemAddr;
  logic [1:0]    MemAddr2;
  logic          Run, Busy, Halted, Error;
  logic          Run2, Busy2, Halted2, Error2;
  logic [7:0]    InstrCount, InstrCount2;

  logic [8:0] mem  [32];
  logic [8:0] mem2 [4];

  instr_sequencer #(.ADDR_W(AW), .TIMEOUT(TO)) u_dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .MemData(MemData), .Done(Done),
    .MemAddr(MemAddr), .DIN(DIN), .Run(Run), .Busy(Busy), .Halted(Halted),
    .Error(Error), .InstrCount(InstrCount)
  );

  instr_sequencer #(.ADDR_W(2), .TIMEOUT(TO)) u_wrap (
    .Clock(Clock), .Resetn(Resetn), .Start(Start2), .MemData(MemData2), .Done(Done2),
    .MemAddr(MemAddr2), .DIN(DIN2), .Run(Run2), .Busy(Busy2), .Halted(Halted2),
    .Error(Error2), .InstrCount(InstrCount2)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) MemData  <= mem[MemAddr];
  always @(posedge Clock) MemData2 <= mem2[MemAddr2];

  int checks = 0;
  int errors = 0;

  int         lat_q[$];
  logic [8:0] obs_word[$], obs_imm[$];
  logic [8:0] exp_word_q[$], exp_imm_q[$];
  int         runs, first_fetch;
  logic [AW-1:0] addr_c1;
  logic [7:0] cnt_c1;
  logic       err_c1, halt_c1, busy_c1;
  int         exp_end, exp_cnt;
  bit         exp_halt, exp_err;

  typedef struct {
    logic [8:0] m0, m1, m2;
    int         k;
    int         nruns;
    logic [8:0] din0, din1;
    int         endc;
    bit         halt, err;
    int         cnt;
    int         fetch;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts the DUT and plays the processor: Done arrives k cycles after Run
  // (k from lat_q, 0 = never). Noise adds Done in ISSUE/FETCH and Start in WAIT.
  task automatic run_prog(input int budget, input bit noise, output int end_cyc);
    int  since, k_cur;
    bit  active, fetch_flag;
    obs_word.delete();
    obs_imm.delete();
    first_fetch = -1;
    runs = 0;
    since = 0;
    k_cur = 0;
    active = 0;
    fetch_flag = 0;
    end_cyc = 0;
    @(negedge Clock);
    Start = 1'b1;
    Done  = 1'b0;
    @(negedge Clock);
    Start = 1'b0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (cyc > 1) @(negedge Clock);
      Done  = 1'b0;
      Start = 1'b0;
      if (cyc == 1) begin
        addr_c1 = MemAddr; cnt_c1 = InstrCount; err_c1 = Error;
        halt_c1 = Halted;  busy_c1 = Busy;
      end
      if (Halted || Error) begin
        end_cyc = cyc;
        break;
      end
      if (fetch_flag) begin
        if (first_fetch < 0) first_fetch = int'(MemAddr);
        fetch_flag = 0;
        if (noise) Done = 1'b1;
      end else if (Run) begin
        runs++;
        obs_word.push_back(DIN);
        k_cur  = (runs - 1 < lat_q.size()) ? lat_q[runs-1] : 1;
        since  = 0;
        active = 1;
        if (noise) Done = 1'b1;
      end else if (active) begin
        since++;
        if (since == 1) obs_imm.push_back(DIN);
        if (noise && since == 2) Start = 1'b1;
        if (since == k_cur) begin
          Done = 1'b1;
          active = 0;
          fetch_flag = 1;
        end
      end
    end
    Done  = 1'b0;
    Start = 1'b0;
  endtask

  task automatic fill_halt();
    for (int a = 0; a < 32; a++) mem[a] = HALTW;
  endtask

  // Random straight-line program plus a model that walks it instruction by
  // instruction, choosing each Done latency and predicting issue words, the
  // final state, the retire count and the cycle at which HALT/ERROR appears.
  task automatic gen_random();
    int addr, len, pc, op, k, lim, r, retired;
    logic [8:0] w;
    bit ismvi;
    fill_halt();
    len  = $urandom_range(1, 24);
    addr = 0;
    while (addr < len) begin
      w = 9'($urandom_range(0, 511));
      op = $urandom_range(0, 6);
      w[8:6] = 3'(op);
      mem[addr] = w;
      if (op == 1) begin
        mem[addr+1] = 9'($urandom_range(0, 511));
        addr += 2;
      end else begin
        addr += 1;
      end
    end
    lat_q.delete(); exp_word_q.delete(); exp_imm_q.delete();
    pc = 0; retired = 0; exp_end = 1; exp_halt = 0; exp_err = 0;
    for (int n = 0; n < 64; n++) begin
      w = mem[pc];
      if (w[8:6] == 3'b111) begin
        exp_halt = 1;
        exp_end += 2;
        break;
      end
      ismvi = (w[8:6] == 3'b001);
      lim = int'(TO) + (ismvi ? 1 : 0);
      r = $urandom_range(0, 29);
      k = (r == 0) ? lim : (r == 1) ? lim + 1 : $urandom_range(1, 6);
      lat_q.push_back(k);
      exp_word_q.push_back(w);
      exp_imm_q.push_back(ismvi ? mem[(pc + 1) % 32] : w);
      if (k > lim) begin
        exp_err = 1;
        exp_end += 3 + lim;
        break;
      end
      retired++;
      exp_end += 3 + k;
      pc = (pc + (ismvi ? 2 : 1)) % 32;
    end
    exp_cnt = (retired > 255) ? 255 : retired;
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int endc, ph, runs2, n;
    bit noise;

    tbl[0]  = '{9'h00A, HALTW, HALTW,  1, 1, 9'h00A, 9'h00A,  7, 1, 0, 1,  1};
    tbl[1]  = '{9'h058, 9'h0AB, HALTW, 1, 1, 9'h058, 9'h0AB,  7, 1, 0, 1,  2};
    tbl[2]  = '{9'h091, HALTW, HALTW,  0, 1, 9'h091, 9'h091, 19, 0, 1, 0, -1};
    tbl[3]  = '{9'h048, 9'h1FF, HALTW, 16, 1, 9'h048, 9'h1FF, 22, 1, 0, 1,  2};
    tbl[4]  = '{9'h048, 9'h1FF, HALTW, 17, 1, 9'h048, 9'h1FF, 20, 0, 1, 0, -1};
    tbl[5]  = '{9'h0D3, HALTW, HALTW, 15, 1, 9'h0D3, 9'h0D3, 21, 1, 0, 1,  1};
    tbl[6]  = '{9'h0D3, HALTW, HALTW, 16, 1, 9'h0D3, 9'h0D3, 19, 0, 1, 0, -1};
    tbl[7]  = '{9'h12C, HALTW, HALTW,  3, 1, 9'h12C, 9'h12C,  9, 1, 0, 1,  1};
    tbl[8]  = '{HALTW, HALTW, HALTW,   1, 0, 9'h000, 9'h000,  3, 1, 0, 0, -1};
    tbl[9]  = '{9'h040, HALTW, HALTW,  2, 1, 9'h040, HALTW,   8, 1, 0, 1,  2};
    tbl[10] = '{9'h1BF, HALTW, HALTW,  1, 1, 9'h1BF, 9'h1BF,  7, 1, 0, 1,  1};

    Resetn = 1'b0; Start = 1'b0; Done = 1'b0; Start2 = 1'b0; Done2 = 1'b0;
    fill_halt();
    for (int a = 0; a < 4; a++) mem2[a] = HALTW;
    repeat (2) @(negedge Clock);
    check("reset MemAddr", MemAddr, 0);
    check("reset DIN", DIN, 0);
    check("reset Run", Run, 0);
    check("reset Busy", Busy, 0);
    check("reset Halted", Halted, 0);
    check("reset Error", Error, 0);
    check("reset InstrCount", InstrCount, 0);
    check("reset wrap Busy", Busy2, 0);
    Resetn = 1'b1;
    @(negedge Clock);
    check("idle without Start", Busy, 0);

    for (int i = 0; i < NV; i++) begin
      fill_halt();
      mem[0] = tbl[i].m0; mem[1] = tbl[i].m1; mem[2] = tbl[i].m2;
      lat_q.delete();
      lat_q.push_back(tbl[i].k);
      run_prog(60, 1'b0, endc);
      check($sformatf("v%0d start addr", i), addr_c1, 0);
      check($sformatf("v%0d start count", i), cnt_c1, 0);
      check($sformatf("v%0d start flags", i), {halt_c1, err_c1, busy_c1}, 3'b001);
      check($sformatf("v%0d end cycle", i), endc, tbl[i].endc);
      check($sformatf("v%0d Halted", i), Halted, tbl[i].halt);
      check($sformatf("v%0d Error", i), Error, tbl[i].err);
      check($sformatf("v%0d Busy/Run/DIN", i), {Busy, Run, DIN}, 0);
      check($sformatf("v%0d InstrCount", i), InstrCount, tbl[i].cnt);
      check($sformatf("v%0d run count", i), runs, tbl[i].nruns);
      if (tbl[i].nruns > 0 && obs_word.size() > 0 && obs_imm.size() > 0) begin
        check($sformatf("v%0d DIN at Run", i), obs_word[0], tbl[i].din0);
        check($sformatf("v%0d DIN after Run", i), obs_imm[0], tbl[i].din1);
      end
      if (tbl[i].fetch >= 0) check($sformatf("v%0d next fetch", i), first_fetch, tbl[i].fetch);
    end

    // Error is sticky against Done, then cleared by Start.
    fill_halt(); mem[0] = 9'h091;
    lat_q.delete(); lat_q.push_back(0);
    run_prog(60, 1'b0, endc);
    check("timeout end cycle", endc, 19);
    for (int c = 0; c < 6; c++) begin
      Done = c[0];
      @(negedge Clock);
    end
    Done = 1'b0;
    check("error sticky", {Error, Busy, Run, DIN}, {1'b1, 11'd0});
    fill_halt(); mem[0] = 9'h00A;
    lat_q.delete(); lat_q.push_back(1);
    run_prog(60, 1'b0, endc);
    check("error restart addr", addr_c1, 0);
    check("error restart cleared", {err_c1, busy_c1}, 2'b01);
    check("error restart end", endc, 7);

    // Wrap on a 4-word ROM: mvi@0, mv@2, mvi@3 whose immediate comes from address 0.
    mem2[0] = 9'h055; mem2[1] = HALTW; mem2[2] = 9'h000; mem2[3] = 9'h040;
    @(negedge Clock); Start2 = 1'b1; Done2 = 1'b1;
    @(negedge Clock); Start2 = 1'b0;
    ph = 0; runs2 = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge Clock);
      if (Halted2) break;
      if (ph == 2) begin check("wrap next fetch", MemAddr2, 1); ph = 3; end
      if (ph == 1) begin
        check("wrap imm addr", MemAddr2, 0);
        check("wrap imm DIN", DIN2, 9'h055);
        ph = 2;
      end
      if (Run2) begin
        runs2++;
        if (DIN2 == 9'h040) begin check("wrap issue addr", MemAddr2, 0); ph = 1; end
      end
    end
    Done2 = 1'b0;
    check("wrap sequence seen", ph, 3);
    check("wrap Halted", Halted2, 1);
    check("wrap InstrCount", InstrCount2, 3);
    check("wrap runs", runs2, 3);

    // Reset in the WAIT of the third instruction.
    fill_halt(); mem[0] = 9'h00A; mem[1] = 9'h00A; mem[2] = 9'h091;
    lat_q.delete(); lat_q.push_back(1); lat_q.push_back(1); lat_q.push_back(0);
    run_prog(14, 1'b0, endc);
    check("pre-reset count", InstrCount, 2);
    check("pre-reset busy", Busy, 1);
    #2 Resetn = 1'b0;
    #1;
    check("async reset outputs", {MemAddr, DIN, Run, Busy, Halted, Error, InstrCount}, 0);
    @(negedge Clock); Resetn = 1'b1;
    fill_halt(); mem[0] = 9'h00A;
    lat_q.delete(); lat_q.push_back(1);
    run_prog(60, 1'b0, endc);
    check("post-reset addr", addr_c1, 0);
    check("post-reset count", cnt_c1, 0);
    check("post-reset end", endc, 7);
    check("post-reset retired", InstrCount, 1);

    for (int it = 0; it < 25; it++) begin
      gen_random();
      noise = 1'($urandom_range(0, 1));
      run_prog(900, noise, endc);
      check($sformatf("r%0d end cycle", it), endc, exp_end);
      check($sformatf("r%0d Halted", it), Halted, exp_halt);
      check($sformatf("r%0d Error", it), Error, exp_err);
      check($sformatf("r%0d InstrCount", it), InstrCount, exp_cnt);
      check($sformatf("r%0d runs", it), runs, exp_word_q.size());
      n = (obs_word.size() < exp_word_q.size()) ? obs_word.size() : exp_word_q.size();
      if (obs_imm.size() < n) n = obs_imm.size();
      for (int j = 0; j < n; j++) begin
        check($sformatf("r%0d word %0d", it, j), obs_word[j], exp_word_q[j]);
        check($sformatf("r%0d imm %0d", it, j), obs_imm[j], exp_imm_q[j]);
      end
    end

    // Saturation with an all-mv ROM: one retirement every 4 cycles.
    for (int a = 0; a < 32; a++) mem[a] = 9'h000;
    lat_q.delete();
    run_prog(1018, 1'b0, endc);
    check("sat 254 no end", endc, 0);
    check("sat 254 count", InstrCount, 254);
    @(negedge Clock); Resetn = 1'b0;
    @(negedge Clock); Resetn = 1'b1;
    run_prog(1100, 1'b0, endc);
    check("sat 255 count", InstrCount, 255);
    check("sat runs", runs, 275);
    check("sat busy", Busy, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
